// File: rtl/uram_polyvec_stream.sv
// uram_polyvec_stream
//   Polyvec store for NUM_POLY polynomials of COE_WIDTH-bit coefficients,
//   packed two per URAM word across ceil(NUM_POLY/2) URAMs sharing one address.
//   A burst sequencer takes {we, base, len} commands and then sinks a write
//   stream or sources a read stream (valid/last framing, no backpressure).
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   cmd_valid/ready     command handshake; cmd_we selects write(1)/read(0)
//   cmd_base, cmd_len   first word address, burst length minus one
//   wr_valid/ready      write beat handshake, wr_data poly p at [p*COE_WIDTH +: COE_WIDTH]
//   rd_valid/last/data  read beat stream, rd_data forced to 0 when rd_valid=0
//   busy                sequencer not idle
//   done                one-cycle pulse on burst completion
module uram_polyvec_stream #(
    parameter int unsigned COE_WIDTH         = 35,
    parameter int unsigned ADDR_WIDTH        = 12,
    parameter int unsigned NUM_POLY          = 4,
    parameter int unsigned COMMON_URAM_DELAY = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_we,
    input  logic [ADDR_WIDTH-1:0]           cmd_base,
    input  logic [ADDR_WIDTH-1:0]           cmd_len,
    input  logic                            wr_valid,
    output logic                            wr_ready,
    input  logic [NUM_POLY*COE_WIDTH-1:0]   wr_data,
    output logic                            rd_valid,
    output logic [NUM_POLY*COE_WIDTH-1:0]   rd_data,
    output logic                            rd_last,
    output logic                            busy,
    output logic                            done
);
    localparam int unsigned LAT   = COMMON_URAM_DELAY + 1;
    localparam int unsigned NURAM = (NUM_POLY + 1) / 2;
    localparam int unsigned DW    = NUM_POLY * COE_WIDTH;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_e;

    state_e                 state_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [ADDR_WIDTH-1:0]  cnt_q;
    logic                   cmd_ready_q;
    logic                   wr_ready_q;
    logic                   busy_q;
    logic                   done_q;
    logic [LAT-1:0]         vld_q;
    logic [LAT-1:0]         lst_q;

    logic                   wr_fire;
    logic                   iss_v;
    logic                   iss_l;
    logic                   mem_en;
    logic                   mem_we;
    logic                   pre_end;
    logic [DW-1:0]          rd_raw;

    assign wr_fire = (state_q == WRITE) && wr_valid && wr_ready_q;
    assign iss_v   = (state_q == READ);
    assign iss_l   = iss_v && (cnt_q == '0);
    assign mem_en  = wr_fire || iss_v;
    assign mem_we  = wr_fire;

    // The tagged last beat is one stage away from the output; registering done
    // from here makes it coincide with rd_valid & rd_last.
    generate
        if (LAT >= 2) begin : g_pre
            assign pre_end = vld_q[LAT-2] && lst_q[LAT-2];
        end else begin : g_pre_direct
            assign pre_end = iss_l;
        end
    endgenerate

    // Burst sequencer. A command is never accepted in the cycle that carries
    // done, so the completion pulse always precedes the next burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b1;
            wr_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        addr_q      <= cmd_base;
                        cnt_q       <= cmd_len;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (cmd_we) begin
                            state_q    <= WRITE;
                            wr_ready_q <= 1'b1;
                        end else begin
                            state_q <= READ;
                        end
                    end
                end
                WRITE: begin
                    if (wr_fire) begin
                        addr_q <= addr_q + ADDR_WIDTH'(1);
                        cnt_q  <= cnt_q - ADDR_WIDTH'(1);
                        if (cnt_q == '0) begin
                            state_q    <= IDLE;
                            wr_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                        end
                    end
                end
                READ: begin
                    addr_q <= addr_q + ADDR_WIDTH'(1);
                    cnt_q  <= cnt_q - ADDR_WIDTH'(1);
                    if (cnt_q == '0) state_q <= DRAIN;
                    if (pre_end) done_q <= 1'b1;
                end
                DRAIN: begin
                    if (pre_end) done_q <= 1'b1;
                    if (rd_valid && rd_last) begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // {valid,last} travel alongside the URAM read pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            lst_q <= '0;
        end else begin
            vld_q[0] <= iss_v;
            lst_q[0] <= iss_l;
            for (int unsigned i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                lst_q[i] <= lst_q[i-1];
            end
        end
    end

    // URAM bank: one array plus NBPIPE output stages per URAM. With an odd
    // NUM_POLY the unused top half of the last URAM is not built.
    for (genvar u = 0; u < NURAM; u++) begin : g_uram
        localparam int unsigned LO = 2 * u * COE_WIDTH;
        localparam int unsigned UW = (2 * u + 1 < NUM_POLY) ? 2 * COE_WIDTH : COE_WIDTH;

        logic [UW-1:0] mem    [DEPTH];
        logic [UW-1:0] pipe_q [LAT];

        always_ff @(posedge clk) begin
            if (mem_en) begin
                if (mem_we) mem[addr_q] <= wr_data[LO +: UW];
                else        pipe_q[0]   <= mem[addr_q];
            end
            for (int unsigned i = 1; i < LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end

        assign rd_raw[LO +: UW] = pipe_q[LAT-1];
    end

    assign rd_valid  = vld_q[LAT-1];
    assign rd_last   = lst_q[LAT-1];
    assign rd_data   = rd_raw & {DW{vld_q[LAT-1]}};
    assign cmd_ready = cmd_ready_q;
    assign wr_ready  = wr_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_uram_polyvec_stream.sv
module tb_uram_polyvec_stream;
    localparam int unsigned CW = 35;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int unsigned ncmp = 0;
    int unsigned nerr = 0;

    // DUT A: NUM_POLY=4, L=2
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [11:0]   cmd_base, cmd_len;
    logic          wr_valid, wr_ready;
    logic [4*CW-1:0] wr_data, rd_data;
    logic          rd_valid, rd_last, busy, done;

    // DUT B: NUM_POLY=3, L=4
    logic          c2_valid, c2_ready, c2_we;
    logic [11:0]   c2_base, c2_len;
    logic          w2_valid, w2_ready;
    logic [3*CW-1:0] w2_data, r2_data;
    logic          r2_valid, r2_last, busy2, done2;

    uram_polyvec_stream #(.COE_WIDTH(CW), .ADDR_WIDTH(12), .NUM_POLY(4), .COMMON_URAM_DELAY(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_base(cmd_base), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
        .busy(busy), .done(done)
    );

    uram_polyvec_stream #(.COE_WIDTH(CW), .ADDR_WIDTH(12), .NUM_POLY(3), .COMMON_URAM_DELAY(3)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(c2_valid), .cmd_ready(c2_ready), .cmd_we(c2_we),
        .cmd_base(c2_base), .cmd_len(c2_len),
        .wr_valid(w2_valid), .wr_ready(w2_ready), .wr_data(w2_data),
        .rd_valid(r2_valid), .rd_data(r2_data), .rd_last(r2_last),
        .busy(busy2), .done(done2)
    );

    // poly p coefficient = seed + 16*p + k
    function automatic logic [4*CW-1:0] mk4(input logic [CW-1:0] seed, input int unsigned k);
        logic [4*CW-1:0] r;
        r = '0;
        for (int p = 0; p < 4; p++) r[p*CW +: CW] = seed + CW'(16 * p + k);
        return r;
    endfunction

    function automatic logic [3*CW-1:0] mk3(input logic [CW-1:0] seed, input int unsigned k);
        logic [3*CW-1:0] r;
        r = '0;
        for (int p = 0; p < 3; p++) r[p*CW +: CW] = seed + CW'(16 * p + k);
        return r;
    endfunction

    // Offer a command on DUT A until accepted (bounded); returns at the first
    // cycle of the burst state.
    task automatic do_cmd(input logic we, input logic [11:0] base, input logic [11:0] len,
                          output logic acc);
        acc = 1'b0;
        cmd_valid = 1'b1; cmd_we = we; cmd_base = base; cmd_len = len;
        for (int i = 0; i < 20 && !acc; i++) begin
            if (cmd_ready === 1'b1) acc = 1'b1;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        ncmp++;
        if ({cmd_ready, wr_ready, rd_valid, rd_last, busy, done} !== 6'b100000) begin
            nerr++;
            $display("FAIL reset_flags: got %b want 100000",
                     {cmd_ready, wr_ready, rd_valid, rd_last, busy, done});
        end
        ncmp++;
        if (rd_data !== '0) begin nerr++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    endtask

    task automatic test_write_read();
        logic acc;
        logic bad;
        logic [2:0] ef;
        logic [4*CW-1:0] ed;
        do_cmd(1'b1, 12'd0, 12'd7, acc);
        ncmp++; if (acc !== 1'b1) begin nerr++; $display("FAIL wr_cmd_accept: got %b want 1", acc); end
        bad = 1'b0;
        for (int k = 0; k < 8; k++) begin
            wr_valid = 1'b1; wr_data = mk4('0, k);
            if (done !== 1'b0 || wr_ready !== 1'b1 || busy !== 1'b1) bad = 1'b1;
            @(negedge clk);
        end
        wr_valid = 1'b0;
        ncmp++; if (bad !== 1'b0) begin nerr++; $display("FAIL wr_stream_flags: got bad=%b want 0", bad); end
        ncmp++;
        if ({done, busy} !== 2'b10) begin nerr++; $display("FAIL wr_done: got %b want 10", {done, busy}); end
        @(negedge clk);
        ncmp++;
        if ({done, cmd_ready} !== 2'b01) begin nerr++; $display("FAIL wr_after_done: got %b want 01", {done, cmd_ready}); end

        do_cmd(1'b0, 12'd0, 12'd7, acc);
        ncmp++; if (acc !== 1'b1) begin nerr++; $display("FAIL rd_cmd_accept: got %b want 1", acc); end
        for (int j = 1; j <= 12; j++) begin
            ef = {(j >= 3 && j <= 10), (j == 10), (j == 10)};
            ed = (j >= 3 && j <= 10) ? mk4('0, j - 3) : '0;
            ncmp++;
            if ({rd_valid, rd_last, done} !== ef) begin
                nerr++; $display("FAIL rd_flags j=%0d: got %b want %b", j, {rd_valid, rd_last, done}, ef);
            end
            ncmp++;
            if (rd_data !== ed) begin nerr++; $display("FAIL rd_data j=%0d: got %h want %h", j, rd_data, ed); end
            @(negedge clk);
        end
    endtask

    task automatic test_wrap();
        localparam logic [CW-1:0] SW = 35'h7_0000_0A00;
        logic acc;
        logic [2:0] ef;
        logic [4*CW-1:0] ed;
        do_cmd(1'b1, 12'd4094, 12'd3, acc);
        ncmp++; if (acc !== 1'b1) begin nerr++; $display("FAIL wrap_wcmd: got %b want 1", acc); end
        for (int k = 0; k < 4; k++) begin
            wr_valid = 1'b1; wr_data = mk4(SW, k);
            @(negedge clk);
        end
        wr_valid = 1'b0;
        ncmp++; if (done !== 1'b1) begin nerr++; $display("FAIL wrap_wdone: got %b want 1", done); end

        do_cmd(1'b0, 12'd4094, 12'd3, acc);
        for (int j = 1; j <= 7; j++) begin
            ef = {(j >= 3 && j <= 6), (j == 6), (j == 6)};
            ed = (j >= 3 && j <= 6) ? mk4(SW, j - 3) : '0;
            ncmp++;
            if ({rd_valid, rd_last, done} !== ef) begin
                nerr++; $display("FAIL wrap_flags j=%0d: got %b want %b", j, {rd_valid, rd_last, done}, ef);
            end
            ncmp++;
            if (rd_data !== ed) begin nerr++; $display("FAIL wrap_data j=%0d: got %h want %h", j, rd_data, ed); end
            @(negedge clk);
        end

        // words C, D must sit at addresses 0 and 1
        do_cmd(1'b0, 12'd0, 12'd1, acc);
        for (int j = 1; j <= 5; j++) begin
            ed = (j >= 3 && j <= 4) ? mk4(SW, j - 1) : '0;
            ncmp++;
            if ({rd_valid, rd_last} !== {(j >= 3 && j <= 4), (j == 4)}) begin
                nerr++; $display("FAIL wrap0_flags j=%0d: got %b", j, {rd_valid, rd_last});
            end
            ncmp++;
            if (rd_data !== ed) begin nerr++; $display("FAIL wrap0_data j=%0d: got %h want %h", j, rd_data, ed); end
            @(negedge clk);
        end
    endtask

    task automatic test_bubbles();
        localparam logic [CW-1:0] SB = 35'h2_0000_0200;
        logic acc;
        int nacc, last_t, dn_t, dn_cnt;
        logic [4*CW-1:0] ed;
        do_cmd(1'b1, 12'd16, 12'd7, acc);
        nacc = 0; last_t = -1; dn_t = -1; dn_cnt = 0;
        for (int t = 0; t < 40; t++) begin
            if (done === 1'b1) begin dn_cnt++; if (dn_t < 0) dn_t = t; end
            if (nacc < 8 && (t % 3) == 0) begin
                wr_valid = 1'b1; wr_data = mk4(SB, nacc);
            end else begin
                wr_valid = 1'b0; wr_data = '1;
            end
            if (wr_valid && wr_ready === 1'b1) begin nacc++; last_t = t; end
            @(negedge clk);
        end
        wr_valid = 1'b0;
        ncmp++; if (nacc != 8) begin nerr++; $display("FAIL bub_beats: got %0d want 8", nacc); end
        ncmp++; if (last_t != 21) begin nerr++; $display("FAIL bub_last_beat: got %0d want 21", last_t); end
        ncmp++; if (dn_t != 22) begin nerr++; $display("FAIL bub_done_time: got %0d want 22", dn_t); end
        ncmp++; if (dn_cnt != 1) begin nerr++; $display("FAIL bub_done_count: got %0d want 1", dn_cnt); end

        do_cmd(1'b0, 12'd16, 12'd7, acc);
        for (int j = 1; j <= 11; j++) begin
            ed = (j >= 3 && j <= 10) ? mk4(SB, j - 3) : '0;
            ncmp++;
            if ({rd_valid, rd_last} !== {(j >= 3 && j <= 10), (j == 10)}) begin
                nerr++; $display("FAIL bub_rd_flags j=%0d: got %b", j, {rd_valid, rd_last});
            end
            ncmp++;
            if (rd_data !== ed) begin nerr++; $display("FAIL bub_rd_data j=%0d: got %h want %h", j, rd_data, ed); end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        localparam logic [CW-1:0] SBB  = 35'h1_0000_0300;
        localparam logic [CW-1:0] SBB2 = 35'h0_0000_0400;
        logic [4:0] ef;
        logic [4*CW-1:0] ed;
        for (int j = 0; j <= 11; j++) begin
            if (j >= 1) begin
                ef = {(j == 4 || j == 9), ((j >= 1 && j <= 2) || j == 10),
                      (j == 3 || j == 8 || j == 11), (j == 7 || j == 8), (j == 8)};
                ed = (j == 7) ? mk4(SBB, 0) : (j == 8) ? mk4(SBB, 1) : '0;
                ncmp++;
                if ({cmd_ready, wr_ready, done, rd_valid, rd_last} !== ef) begin
                    nerr++;
                    $display("FAIL b2b_flags j=%0d: got %b want %b", j,
                             {cmd_ready, wr_ready, done, rd_valid, rd_last}, ef);
                end
                ncmp++;
                if (rd_data !== ed) begin nerr++; $display("FAIL b2b_data j=%0d: got %h want %h", j, rd_data, ed); end
            end
            cmd_valid = (j <= 9);
            if (j == 0) begin
                cmd_we = 1'b1; cmd_base = 12'd32; cmd_len = 12'd1;
            end else if (j <= 4) begin
                cmd_we = 1'b0; cmd_base = 12'd32; cmd_len = 12'd1;
            end else begin
                cmd_we = 1'b1; cmd_base = 12'd40; cmd_len = 12'd0;
            end
            wr_valid = (j == 1 || j == 2 || j == 10);
            wr_data  = (j == 10) ? mk4(SBB2, 0) : (j == 0) ? '0 : mk4(SBB, j - 1);
            @(negedge clk);
        end
        cmd_valid = 1'b0; wr_valid = 1'b0;
    endtask

    task automatic test_odd_poly();
        localparam logic [CW-1:0] S3 = 35'h4_5000_0300;
        logic [2:0] ef;
        logic [3*CW-1:0] ed;
        c2_valid = 1'b1; c2_we = 1'b1; c2_base = 12'd7; c2_len = 12'd2;
        ncmp++; if (c2_ready !== 1'b1) begin nerr++; $display("FAIL odd_wcmd: got %b want 1", c2_ready); end
        @(negedge clk);
        c2_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            w2_valid = 1'b1; w2_data = mk3(S3, k);
            @(negedge clk);
        end
        w2_valid = 1'b0;
        ncmp++; if (done2 !== 1'b1) begin nerr++; $display("FAIL odd_wdone: got %b want 1", done2); end
        @(negedge clk);
        c2_valid = 1'b1; c2_we = 1'b0; c2_base = 12'd7; c2_len = 12'd2;
        ncmp++; if (c2_ready !== 1'b1) begin nerr++; $display("FAIL odd_rcmd: got %b want 1", c2_ready); end
        @(negedge clk);
        c2_valid = 1'b0;
        for (int j = 1; j <= 9; j++) begin
            ef = {(j >= 5 && j <= 7), (j == 7), (j == 7)};
            ed = (j >= 5 && j <= 7) ? mk3(S3, j - 5) : '0;
            ncmp++;
            if ({r2_valid, r2_last, done2} !== ef) begin
                nerr++; $display("FAIL odd_flags j=%0d: got %b want %b", j, {r2_valid, r2_last, done2}, ef);
            end
            ncmp++;
            if (r2_data !== ed) begin nerr++; $display("FAIL odd_data j=%0d: got %h want %h", j, r2_data, ed); end
            @(negedge clk);
        end
        ncmp++; if (c2_ready !== 1'b1) begin nerr++; $display("FAIL odd_idle: got %b want 1", c2_ready); end
    endtask

    task automatic test_reset_mid_burst();
        logic acc;
        do_cmd(1'b0, 12'd0, 12'd9, acc);
        for (int j = 1; j < 5; j++) @(negedge clk);
        ncmp++; if (rd_valid !== 1'b1) begin nerr++; $display("FAIL rst_pre_valid: got %b want 1", rd_valid); end
        rst_n = 1'b0;
        #1;
        ncmp++;
        if ({rd_valid, busy, done, cmd_ready, wr_ready} !== 5'b00010) begin
            nerr++; $display("FAIL rst_mid_flags: got %b want 00010", {rd_valid, busy, done, cmd_ready, wr_ready});
        end
        ncmp++; if (rd_data !== '0) begin nerr++; $display("FAIL rst_mid_data: got %h want 0", rd_data); end
        @(negedge clk);
        rst_n = 1'b1;
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_base = 12'd60; cmd_len = 12'd0;
        ncmp++; if (cmd_ready !== 1'b1) begin nerr++; $display("FAIL rst_rel_ready: got %b want 1", cmd_ready); end
        @(negedge clk);
        cmd_valid = 1'b0;
        ncmp++;
        if ({wr_ready, busy, done, rd_valid} !== 4'b1100) begin
            nerr++; $display("FAIL rst_new_cmd: got %b want 1100", {wr_ready, busy, done, rd_valid});
        end
        wr_valid = 1'b1; wr_data = mk4(35'h123, 0);
        @(negedge clk);
        wr_valid = 1'b0;
        ncmp++; if (done !== 1'b1) begin nerr++; $display("FAIL rst_new_done: got %b want 1", done); end
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_base = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0;
        c2_valid = 1'b0; c2_we = 1'b0; c2_base = '0; c2_len = '0;
        w2_valid = 1'b0; w2_data = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_wrap();
        test_bubbles();
        test_back_to_back();
        test_odd_poly();
        test_reset_mid_burst();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/uram_polyvec_stream.md
Name: uram_polyvec_stream

Overview:
Parametrised polyvec store for NUM_POLY polynomials of COE_WIDTH-bit coefficients. Coefficients are packed two per sp_uram word, using ceil(NUM_POLY/2) sp_uram instances that share one address. A built-in burst sequencer replaces the raw address port: a command gives a base address and a length, and the block then sinks a write stream or sources a read stream with valid/last framing. The block sits between NTT/reduce engines and the reduce buffer.

Parameters:
COE_WIDTH, 35, coefficient width in bits
ADDR_WIDTH, 12, URAM depth is 2^ADDR_WIDTH words
NUM_POLY, 4, polynomials per word; any value >=1; odd counts leave the top half of the last URAM tied to 0
COMMON_URAM_DELAY, 1, sp_uram NBPIPE; read latency L = COMMON_URAM_DELAY+1

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_we  in  1  1 = write burst, 0 = read burst
cmd_base  in  ADDR_WIDTH  first word address
cmd_len  in  ADDR_WIDTH  burst length minus 1 (1..2^ADDR_WIDTH beats)
wr_valid  in  1  write beat offered
wr_ready  out  1  write beat accepted when wr_valid & wr_ready
wr_data  in  NUM_POLY*COE_WIDTH  coefficient i of poly p at bits [p*COE_WIDTH +: COE_WIDTH]
rd_valid  out  1  read beat valid; no backpressure
rd_data  out  NUM_POLY*COE_WIDTH  read coefficients, same packing as wr_data
rd_last  out  1  final beat of a read burst, coincident with rd_valid
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on burst completion

Behaviour:
- Reset (async assert, synchronous release): state=IDLE, cmd_ready=1, wr_ready=0, rd_valid=0, rd_last=0, busy=0, done=0, rd_data=0. The read-valid shift register is cleared. URAM contents are retained and unspecified after power-up.
- States: IDLE, WRITE, READ, DRAIN.
- IDLE: cmd_ready=1. On acceptance, latch addr=cmd_base and cnt=cmd_len, then go to WRITE if cmd_we=1, otherwise READ.
- WRITE: wr_ready=1, cmd_ready=0. Each accepted beat asserts mem_en=we=1 at addr in the same cycle. It then sets addr<=addr+1 (mod 2^ADDR_WIDTH, so 2^ADDR_WIDTH-1 wraps to 0) and cnt<=cnt-1. A beat accepted with cnt==0 goes to IDLE and pulses done on the next cycle. Bubbles on wr_valid stall the sequence without limit.
- READ: one read per cycle (mem_en=1, we=0), with the same addr/cnt update. The issue with cnt==0 tags "last" and goes to DRAIN. No stalls are possible.
- Valid pipeline: an L-deep shift register carries {valid,last} alongside the URAM pipeline. rd_valid/rd_last rise exactly L cycles after the corresponding issue cycle.
- DRAIN: wait until the tagged beat leaves the pipeline (rd_valid & rd_last). Assert done in that same cycle, then return to IDLE. cmd_ready stays 0 through DRAIN, so read data never interleaves across bursts.
- Throughput: a read burst of N beats takes N+L cycles from acceptance to done. A write burst of N beats takes N cycles with no bubbles, and done follows one cycle later.
- rd_data is ANDed with rd_valid and reads 0 whenever rd_valid=0.
- Ports driven outside their state are ignored: wr_valid outside WRITE, cmd_valid while busy.
- cmd_len=2^ADDR_WIDTH-1 covers the whole memory; the address wraps back to cmd_base after the final beat.
- Reset mid-burst returns to IDLE immediately and flushes pending rd_valid. Words already written stay written; no done pulse is produced.
- Memory write port ordering: read-first behaviour is irrelevant because read and write bursts never overlap.

Test Plan:
- NUM_POLY=4, L=2. Write burst: base 0, len 7, wr_data poly p coeff = 16*p+addr. Read the same range back -> 8 rd_valid beats starting 2 cycles after the first issue, rd_last on beat 8, done in the same cycle, data matches.
- Wrap: write base 4094, len 3 (addresses 4094, 4095, 0, 1) with values A..D. Read base 4094, len 3 -> A, B, C, D in order, rd_last on D.
- wr_valid toggling 1,0,0,1,... on an 8-beat burst -> exactly 8 writes, addresses contiguous, done one cycle after the 8th accepted beat.
- NUM_POLY=3, COMMON_URAM_DELAY=3. Read/write round trip -> 3 polys correct, latency 4, rd_data zero between beats.
- Back-to-back: cmd_valid held high with write then read commands queued -> the read is accepted on the cycle after done. The second cmd is not accepted during DRAIN.
- Reset asserted on the 3rd beat of a 10-beat read -> rd_valid=0, busy=0, done=0 immediately. A new command is accepted on the first cycle after release.
